// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller: selects the next PC every cycle and drives the IF/ID
// and ID/EX enables/flushes. The controller keeps its own copy of the PC
// (pc_reg), which always equals the external PC register because that
// register loads PC_Next on every edge.
//
// IMem_Ready is a plain per-cycle qualifier: when it is high in RUN, the
// word presented this cycle is valid and is accepted into IF/ID. When it is
// low, the PC holds and IF/ID takes a bubble. There is no backpressure on
// the memory side; the same address is simply presented again next cycle.
module pc_fetch_controller #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BOOT_CYCLES  = 2,
  parameter logic [31:0] INSTR_BYTES  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic        Jump,
  input  logic [31:0] Jump_Target,
  input  logic        Stall_Req,
  input  logic        Halt,
  input  logic        Resume,
  input  logic        IMem_Ready,
  output logic [31:0] PC_Next,
  output logic        IF_ID_Enable,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        Fetch_Valid,
  output logic        Halted,
  output logic [15:0] Redirect_Count,
  output logic [1:0]  state_dbg
);

  localparam int BW = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] boot_cnt, boot_cnt_nxt;
  logic [31:0]   pc_reg;
  logic          redirect;

  assign state_dbg = state;

  // State, boot counter and PC mirror registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BOOT;
      boot_cnt <= '0;
      pc_reg   <= RESET_VECTOR;
    end else begin
      state    <= state_nxt;
      boot_cnt <= boot_cnt_nxt;
      pc_reg   <= PC_Next;
    end
  end

  // Saturating count of accepted redirects; a branch and jump together count once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Redirect_Count <= '0;
    end else if (redirect && (Redirect_Count != 16'hFFFF)) begin
      Redirect_Count <= Redirect_Count + 16'd1;
    end
  end

  // Next-state and fetch-control outputs. The BOOT defaults also serve as the
  // reset-time outputs, since reset forces BOOT with pc_reg at RESET_VECTOR.
  always_comb begin
    state_nxt    = state;
    boot_cnt_nxt = boot_cnt;
    PC_Next      = pc_reg;
    IF_ID_Enable = 1'b0;
    IF_ID_Flush  = 1'b1;
    ID_EX_Flush  = 1'b1;
    Fetch_Valid  = 1'b0;
    Halted       = 1'b0;
    redirect     = 1'b0;
    case (state)
      ST_BOOT: begin
        if (boot_cnt == BOOT_LAST) begin
          state_nxt    = ST_RUN;
          boot_cnt_nxt = '0;
        end else begin
          boot_cnt_nxt = boot_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        IF_ID_Enable = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        if (Branch_Taken) begin
          // Branch resolved in EX kills both younger instructions.
          PC_Next     = Branch_Target;
          IF_ID_Flush = 1'b1;
          ID_EX_Flush = 1'b1;
          redirect    = 1'b1;
        end else if (Stall_Req) begin
          // Load-use: freeze IF and ID, insert a bubble into EX.
          IF_ID_Enable = 1'b0;
          ID_EX_Flush  = 1'b1;
        end else if (Halt) begin
          IF_ID_Flush = 1'b1;
          state_nxt   = ST_HALT;
        end else if (Jump) begin
          // Jump decoded in ID only kills the instruction in IF.
          PC_Next     = Jump_Target;
          IF_ID_Flush = 1'b1;
          redirect    = 1'b1;
        end else if (!IMem_Ready) begin
          IF_ID_Flush = 1'b1;
        end else begin
          PC_Next     = pc_reg + INSTR_BYTES;
          Fetch_Valid = 1'b1;
        end
      end
      ST_HALT: begin
        IF_ID_Enable = 1'b1;
        IF_ID_Flush  = 1'b1;
        ID_EX_Flush  = 1'b0;
        Halted       = 1'b1;
        if (Resume) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt    = ST_BOOT;
        boot_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Bench for pc_fetch_controller: directed scenarios with literal expectations
// plus a randomized phase, all cross-checked every cycle against a
// cycle-level reference model of the fetch rules.
module tb_pc_fetch_controller;

  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam int          BOOT = 2;
  localparam logic [31:0] IB   = 32'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        Branch_Taken, Jump, Stall_Req, Halt, Resume, IMem_Ready;
  logic [31:0] Branch_Target, Jump_Target;
  logic [31:0] PC_Next;
  logic        IF_ID_Enable, IF_ID_Flush, ID_EX_Flush, Fetch_Valid, Halted;
  logic [15:0] Redirect_Count;
  logic [1:0]  state_dbg;

  pc_fetch_controller #(
    .RESET_VECTOR(RV), .BOOT_CYCLES(BOOT), .INSTR_BYTES(IB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
    .Jump(Jump), .Jump_Target(Jump_Target),
    .Stall_Req(Stall_Req), .Halt(Halt), .Resume(Resume),
    .IMem_Ready(IMem_Ready),
    .PC_Next(PC_Next), .IF_ID_Enable(IF_ID_Enable),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .Fetch_Valid(Fetch_Valid), .Halted(Halted),
    .Redirect_Count(Redirect_Count), .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_boot: BOOT cycles still to spend; m_halt: halted; m_pc: PC register.
  logic [31:0] m_pc, n_pc, m_cnt, n_cnt;
  int          m_boot, n_boot;
  bit          m_halt, n_halt;

  task automatic m_reset();
    m_pc = RV;  m_boot = BOOT; m_halt = 1'b0; m_cnt = 0;
    n_pc = RV;  n_boot = BOOT; n_halt = 1'b0; n_cnt = 0;
  endtask

  always @(negedge rst_n) m_reset();

  // Compare process: predicts this cycle's outputs and next-cycle model state.
  always @(negedge clk) begin : compare
    logic [31:0] e_pc;
    logic        e_en, e_iff, e_idf, e_fv, e_halted;
    logic [1:0]  e_st;
    int          red;
    if (!rst_n) m_reset();
    e_pc = m_pc; e_en = 0; e_iff = 1; e_idf = 1; e_fv = 0; red = 0;
    n_boot = m_boot; n_halt = m_halt;
    if (m_boot > 0) begin
      n_boot = m_boot - 1;
    end else if (m_halt) begin
      e_en = 1; e_idf = 0;
      if (Resume) n_halt = 0;
    end else begin
      e_en = 1; e_iff = 0; e_idf = 0;
      if (Branch_Taken) begin
        e_pc = Branch_Target; e_iff = 1; e_idf = 1; red = 1;
      end else if (Stall_Req) begin
        e_en = 0; e_idf = 1;
      end else if (Halt) begin
        e_iff = 1; n_halt = 1;
      end else if (Jump) begin
        e_pc = Jump_Target; e_iff = 1; red = 1;
      end else if (!IMem_Ready) begin
        e_iff = 1;
      end else begin
        e_pc = m_pc + IB; e_fv = 1;
      end
    end
    n_pc  = e_pc;
    n_cnt = (m_cnt + 32'(red) > 32'd65535) ? 32'd65535 : m_cnt + 32'(red);
    e_halted = (m_boot == 0) && m_halt;
    e_st = (m_boot > 0) ? 2'd0 : (m_halt ? 2'd2 : 2'd1);
    chk("pc_next",      PC_Next,               e_pc);
    chk("if_id_enable", 32'(IF_ID_Enable),     32'(e_en));
    chk("if_id_flush",  32'(IF_ID_Flush),      32'(e_iff));
    chk("id_ex_flush",  32'(ID_EX_Flush),      32'(e_idf));
    chk("fetch_valid",  32'(Fetch_Valid),      32'(e_fv));
    chk("halted",       32'(Halted),           32'(e_halted));
    chk("redirect_cnt", 32'(Redirect_Count),   m_cnt);
    chk("state_dbg",    32'(state_dbg),        32'(e_st));
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_pc = n_pc; m_boot = n_boot; m_halt = n_halt; m_cnt = n_cnt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drv(input logic b, input logic [31:0] bt, input logic j,
                     input logic [31:0] jt, input logic s, input logic h,
                     input logic r, input logic im);
    Branch_Taken = b; Branch_Target = bt; Jump = j; Jump_Target = jt;
    Stall_Req = s; Halt = h; Resume = r; IMem_Ready = im;
  endtask

  task automatic idle();
    drv(0, 32'h0, 0, 32'h0, 0, 0, 0, 1);
  endtask

  task automatic at_chk();
    @(negedge clk); #1;
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  // Branch to a target so the PC register holds it after the edge.
  task automatic go_to(input logic [31:0] pc);
    drv(1, pc, 0, 32'h0, 0, 0, 0, 1);
    at_chk();
    adv();
    idle();
  endtask

  function automatic logic [31:0] rnd_pc();
    return $urandom() & 32'hFFFF_FFFC;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rst_n = 1'b0;
    at_chk();
    chk("rst_pc",    PC_Next, 32'h0);
    chk("rst_en",    32'(IF_ID_Enable), 32'd0);
    chk("rst_flush", 32'(IF_ID_Flush & ID_EX_Flush), 32'd1);
    adv(); adv();
    rst_n = 1'b1;

    // Boot then clean sequential fetch.
    at_chk(); chk("boot0_pc", PC_Next, 32'h0); chk("boot0_fv", 32'(Fetch_Valid), 32'd0);
    adv(); at_chk(); chk("boot1_pc", PC_Next, 32'h0);
    adv(); at_chk(); chk("run0_pc", PC_Next, 32'h4); chk("run0_fv", 32'(Fetch_Valid), 32'd1);
    adv(); at_chk(); chk("run1_pc", PC_Next, 32'h8);
    adv(); at_chk(); chk("run2_pc", PC_Next, 32'hC);
    adv(); at_chk(); chk("run3_pc", PC_Next, 32'h10);
    adv();

    // Branch wins over stall and jump.
    go_to(32'h20);
    drv(1, 32'h100, 1, 32'h100, 1, 0, 0, 1);
    at_chk();
    chk("prio_pc", PC_Next, 32'h100);
    chk("prio_flush", 32'({IF_ID_Flush, ID_EX_Flush}), 32'd3);
    chk("prio_cnt_before", 32'(Redirect_Count), 32'd1);
    adv(); idle(); at_chk();
    chk("prio_cnt_after", 32'(Redirect_Count), 32'd2);
    chk("prio_next_pc", PC_Next, 32'h104);
    adv();

    // Three-cycle stall.
    go_to(32'h40);
    drv(0, 32'h0, 0, 32'h0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      at_chk();
      chk("stall_pc", PC_Next, 32'h40);
      chk("stall_en", 32'(IF_ID_Enable), 32'd0);
      adv();
    end
    idle(); at_chk(); chk("stall_release_pc", PC_Next, 32'h44); adv();

    // Halt, branch ignored while halted, resume.
    go_to(32'h80);
    drv(0, 32'h0, 0, 32'h0, 0, 1, 0, 1);
    at_chk(); chk("halt_pc", PC_Next, 32'h80); adv();
    drv(1, 32'h500, 0, 32'h0, 0, 0, 0, 1);
    at_chk(); chk("halted_flag", 32'(Halted), 32'd1); chk("halted_pc", PC_Next, 32'h80); adv();
    drv(0, 32'h0, 0, 32'h0, 0, 0, 1, 1);
    at_chk(); chk("resume_pc", PC_Next, 32'h80); adv();
    idle(); at_chk(); chk("resumed_pc", PC_Next, 32'h84); chk("resumed_halted", 32'(Halted), 32'd0);
    adv();

    // Memory wait at the top of the address space, then wrap.
    go_to(32'hFFFF_FFFC);
    drv(0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      at_chk(); chk("wait_pc", PC_Next, 32'hFFFF_FFFC); chk("wait_flush", 32'(IF_ID_Flush), 32'd1);
      adv();
    end
    idle(); at_chk(); chk("wrap_pc", PC_Next, 32'h0); adv();

    // Randomized phase with one reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      drv($urandom_range(0, 99) < 15, rnd_pc(), $urandom_range(0, 99) < 15, rnd_pc(),
          $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
          $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 80);
      if (i == 700) rst_n = 1'b0;
      if (i == 702) rst_n = 1'b1;
      adv();
    end

    // Drive the counter to saturation with back-to-back jumps.
    idle();
    rst_n = 1'b0; adv(); adv(); rst_n = 1'b1;
    repeat (BOOT) adv();
    for (int i = 0; i < 65535; i++) begin
      drv(0, 32'h0, 1, rnd_pc(), 0, 0, 0, 1);
      adv();
    end
    idle(); at_chk(); chk("sat_cnt", 32'(Redirect_Count), 32'hFFFF);
    go_to(32'h1234_5678);
    at_chk(); chk("sat_hold_branch", 32'(Redirect_Count), 32'hFFFF);
    drv(1, 32'h1234_5678, 1, 32'h0, 0, 0, 0, 1);
    at_chk(); adv(); idle();
    at_chk(); chk("sat_hold_both", 32'(Redirect_Count), 32'hFFFF);
    chk("mid_pc", PC_Next, 32'h1234_567C);
    adv();

    // Asynchronous reset mid-run.
    rst_n = 1'b0;
    #1;
    chk("arst_pc",     PC_Next, 32'h0);
    chk("arst_en",     32'(IF_ID_Enable), 32'd0);
    chk("arst_flush",  32'({IF_ID_Flush, ID_EX_Flush}), 32'd3);
    chk("arst_fv",     32'(Fetch_Valid), 32'd0);
    chk("arst_halted", 32'(Halted), 32'd0);
    chk("arst_cnt",    32'(Redirect_Count), 32'd0);
    at_chk(); adv();
    rst_n = 1'b1;
    repeat (5) adv();

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
